// File: rtl/alu_pkg.sv
// Shared EX-stage constants: ALU op codes, M-extension funct3
// values and the multiply/divide FSM state encoding.
package alu_pkg;

  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_SLL  = 4'd2;
  localparam logic [3:0] ALU_SLT  = 4'd3;
  localparam logic [3:0] ALU_SLTU = 4'd4;
  localparam logic [3:0] ALU_XOR  = 4'd5;
  localparam logic [3:0] ALU_SRL  = 4'd6;
  localparam logic [3:0] ALU_SRA  = 4'd7;
  localparam logic [3:0] ALU_OR   = 4'd8;
  localparam logic [3:0] ALU_AND  = 4'd9;

  localparam logic [2:0] MDU_MUL    = 3'b000;
  localparam logic [2:0] MDU_MULH   = 3'b001;
  localparam logic [2:0] MDU_MULHSU = 3'b010;
  localparam logic [2:0] MDU_MULHU  = 3'b011;
  localparam logic [2:0] MDU_DIV    = 3'b100;
  localparam logic [2:0] MDU_DIVU   = 3'b101;
  localparam logic [2:0] MDU_REM    = 3'b110;
  localparam logic [2:0] MDU_REMU   = 3'b111;

  typedef enum logic [1:0] {
    MDU_IDLE = 2'd0,
    MDU_BUSY = 2'd1,
    MDU_DONE = 2'd2
  } mdu_state_t;

  function automatic logic op_is_div(logic [2:0] op);
    return op[2];
  endfunction

  function automatic logic op_sgn_a(logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_MULHSU) ||
           (op == MDU_DIV)  || (op == MDU_REM);
  endfunction

  function automatic logic op_sgn_b(logic [2:0] op);
    return (op == MDU_MULH) || (op == MDU_DIV) ||
           (op == MDU_REM);
  endfunction

endpackage

// File: rtl/mul_div_unit_if.sv
// Request/response handshake between the EX control
// logic and the iterative multiply/divide unit.
interface mul_div_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      op;
  logic [XLEN-1:0] a;
  logic [XLEN-1:0] b;
  logic            flush;
  logic            out_valid;
  logic [XLEN-1:0] result;

  modport master (
    output in_valid, op, a, b, flush,
    input  in_ready, out_valid, result
  );

  modport slave (
    input  in_valid, op, a, b, flush,
    output in_ready, out_valid, result
  );
endinterface

// File: rtl/mdu_step.sv
// One iteration of the MDU datapath: shift-add for multiply,
// restoring trial-subtract for divide.
module mdu_step #(
  parameter int XLEN = 32
) (
  input  logic              div_op,
  input  logic [2*XLEN-1:0] acc_in,
  input  logic [XLEN-1:0]   md,
  output logic [2*XLEN-1:0] acc_out
);

  logic [XLEN:0]   sum;
  logic [XLEN:0]   rem_sh;
  logic [XLEN+1:0] diff;

  always_comb begin
    sum    = {1'b0, acc_in[2*XLEN-1:XLEN]}
           + (acc_in[0] ? {1'b0, md} : '0);
    rem_sh = acc_in[2*XLEN-1:XLEN-1];
    diff   = {1'b0, rem_sh} - {2'b00, md};
    acc_out = {sum, acc_in[XLEN-1:1]};
    if (div_op) begin
      // borrow set: divisor did not fit, keep the shifted remainder
      if (diff[XLEN+1])
        acc_out = {rem_sh[XLEN-1:0], acc_in[XLEN-2:0], 1'b0};
      else
        acc_out = {diff[XLEN-1:0], acc_in[XLEN-2:0], 1'b1};
    end
  end

endmodule

// File: rtl/mul_div_unit.sv
// Iterative RV32M multiply/divide unit: one product or quotient
// bit per cycle, handshake-driven, with fast special-case exits.
module mul_div_unit
  import alu_pkg::*;
#(
  parameter int XLEN         = 32,
  parameter bit FAST_SPECIAL = 1'b1
) (
  input logic           clk,
  input logic           rst,
  mul_div_unit_if.slave bus
);

  if ((XLEN % 2) != 0 || XLEN < 8) begin : g_bad_xlen
    $error("mul_div_unit: XLEN must be even and >= 8");
  end

  localparam int CW = $clog2(XLEN);

  mdu_state_t        state;
  logic [CW-1:0]     cnt;
  logic [2:0]        op_q;
  logic [2*XLEN-1:0] acc;
  logic [2*XLEN-1:0] acc_nx;
  logic [XLEN-1:0]   md;
  logic              neg;
  logic [XLEN-1:0]   res_q;

  logic              sa, sb, b_zero, ovf, special;
  logic              neg_in, accept;
  logic [XLEN-1:0]   abs_a, abs_b, spec_res;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   fin_mul, div_sel, fin_div, fin;

  assign bus.in_ready  = (state != MDU_BUSY);
  assign bus.out_valid = (state == MDU_DONE);
  assign bus.result    = res_q;
  assign accept        = bus.in_valid && bus.in_ready;

  always_comb begin
    sa     = op_sgn_a(bus.op) && bus.a[XLEN-1];
    sb     = op_sgn_b(bus.op) && bus.b[XLEN-1];
    abs_a  = sa ? -bus.a : bus.a;
    abs_b  = sb ? -bus.b : bus.b;
    b_zero = (bus.b == '0);
    ovf    = ((bus.op == MDU_DIV) || (bus.op == MDU_REM))
          && (bus.a == {1'b1, {(XLEN-1){1'b0}}}) && (&bus.b);
    special = op_is_div(bus.op) && (b_zero || ovf);
    if (b_zero)
      spec_res = bus.op[1] ? bus.a : '1;
    else
      spec_res = bus.op[1] ? '0 : bus.a;
    // divide-by-zero quotient stays all ones even on the slow path
    if (op_is_div(bus.op) && bus.op[1])
      neg_in = sa;
    else
      neg_in = (sa ^ sb) && !(op_is_div(bus.op) && b_zero);
  end

  mdu_step #(.XLEN(XLEN)) u_step (
    .div_op  (op_q[2]),
    .acc_in  (acc),
    .md      (md),
    .acc_out (acc_nx)
  );

  always_comb begin
    prod    = neg ? -acc_nx : acc_nx;
    fin_mul = (op_q[1:0] == 2'b00) ? prod[XLEN-1:0]
                                   : prod[2*XLEN-1:XLEN];
    div_sel = op_q[1] ? acc_nx[2*XLEN-1:XLEN] : acc_nx[XLEN-1:0];
    fin_div = neg ? -div_sel : div_sel;
    fin     = op_q[2] ? fin_div : fin_mul;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MDU_IDLE;
      cnt   <= '0;
      op_q  <= '0;
      acc   <= '0;
      md    <= '0;
      neg   <= 1'b0;
      res_q <= '0;
    end else if (bus.flush) begin
      state <= MDU_IDLE;
      cnt   <= '0;
    end else begin
      case (state)
        MDU_BUSY: begin
          acc <= acc_nx;
          cnt <= cnt + 1'b1;
          if (cnt == CW'(XLEN-1)) begin
            res_q <= fin;
            cnt   <= '0;
            state <= MDU_DONE;
          end
        end
        default: begin
          if (accept) begin
            op_q <= bus.op;
            acc  <= {{XLEN{1'b0}}, abs_a};
            md   <= abs_b;
            neg  <= neg_in;
            cnt  <= '0;
            if (FAST_SPECIAL && special) begin
              res_q <= spec_res;
              state <= MDU_DONE;
            end else begin
              state <= MDU_BUSY;
            end
          end else begin
            state <= MDU_IDLE;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// Directed and random checks of mul_div_unit results,
// latency, back-to-back issue, flush and reset.
module tb_mul_div_unit;

  logic clk;
  logic rst;
  int   checks;
  int   fails;

  mul_div_unit_if #(.XLEN(32)) bus ();

  mul_div_unit #(.XLEN(32), .FAST_SPECIAL(1'b1)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] exp;
    int          lat;
  } vec_t;

  vec_t vt[14];

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Drives a request starting #1 after an edge; returns once
  // out_valid is seen (or the cycle budget runs out).
  task automatic do_op(input logic [2:0] o, input logic [31:0] x,
                       input logic [31:0] y, output logic [31:0] r,
                       output int lat);
    bus.in_valid = 1'b1;
    bus.op = o;
    bus.a  = x;
    bus.b  = y;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    lat = 1;
    while (!bus.out_valid && lat < 100) begin
      @(posedge clk);
      #1;
      lat++;
    end
    r = bus.result;
  endtask

  function automatic logic [31:0] model(logic [2:0] o, logic [31:0] x,
                                        logic [31:0] y);
    logic [63:0]        p;
    logic signed [63:0] xs, ys, yu;
    logic               ov;
    xs = {{32{x[31]}}, x};
    ys = {{32{y[31]}}, y};
    yu = {32'b0, y};
    ov = (x == 32'h8000_0000) && (y == 32'hFFFF_FFFF);
    p  = '0;
    case (o)
      3'd0: begin p = {32'b0, x} * {32'b0, y}; return p[31:0]; end
      3'd1: begin p = xs * ys; return p[63:32]; end
      3'd2: begin p = xs * yu; return p[63:32]; end
      3'd3: begin p = {32'b0, x} * {32'b0, y}; return p[63:32]; end
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (ov) return x;
        return $signed(x) / $signed(y);
      end
      3'd5: begin
        if (y == 0) return 32'hFFFF_FFFF;
        return x / y;
      end
      3'd6: begin
        if (y == 0) return x;
        if (ov) return 32'h0;
        return $signed(x) % $signed(y);
      end
      default: begin
        if (y == 0) return x;
        return x % y;
      end
    endcase
  endfunction

  function automatic int model_lat(logic [2:0] o, logic [31:0] x,
                                   logic [31:0] y);
    if (o[2] && y == 0) return 1;
    if ((o == 3'd4 || o == 3'd6) && x == 32'h8000_0000 &&
        y == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  initial begin
    logic [31:0] r, r2, keep;
    logic [2:0]  o;
    logic [31:0] x, y;
    int          lat, ov_cnt;

    checks = 0;
    fails  = 0;

    vt[0]  = '{3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 33};
    vt[1]  = '{3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 33};
    vt[2]  = '{3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 33};
    vt[3]  = '{3'd2, 32'hFFFF_FFFF, 32'd2,         32'hFFFF_FFFF, 33};
    vt[4]  = '{3'd4, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFD, 33};
    vt[5]  = '{3'd6, 32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 33};
    vt[6]  = '{3'd5, 32'hFFFF_FFFF, 32'd16,        32'h0FFF_FFFF, 33};
    vt[7]  = '{3'd4, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vt[8]  = '{3'd6, 32'd5,          32'd0,         32'd5,         1};
    vt[9]  = '{3'd5, 32'd5,          32'd0,         32'hFFFF_FFFF, 1};
    vt[10] = '{3'd7, 32'd5,          32'd0,         32'd5,         1};
    vt[11] = '{3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1};
    vt[12] = '{3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1};
    vt[13] = '{3'd4, 32'hFFFF_FFFB, 32'd0,         32'hFFFF_FFFF, 1};

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_result", bus.result, 32'h0);
    chk("rst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("rst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    for (int i = 0; i < 14; i++) begin
      do_op(vt[i].op, vt[i].a, vt[i].b, r, lat);
      chk($sformatf("vec%0d_result", i), r, vt[i].exp);
      chk($sformatf("vec%0d_latency", i), 32'(lat), 32'(vt[i].lat));
    end

    for (int i = 0; i < 24; i++) begin
      o = 3'($urandom_range(0, 7));
      x = $urandom;
      y = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
      if ($urandom_range(0, 3) == 0) y = 32'($urandom_range(1, 20));
      do_op(o, x, y, r, lat);
      chk($sformatf("rnd%0d_op%0d_result", i, o), r, model(o, x, y));
      chk($sformatf("rnd%0d_latency", i), 32'(lat), 32'(model_lat(o, x, y)));
    end

    // back-to-back: second request issued in the DONE cycle
    do_op(3'd0, 32'd7, 32'hFFFF_FFFD, r, lat);
    chk("b2b_first_result", r, 32'hFFFF_FFEB);
    chk("b2b_done_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("b2b_done_out_valid", {31'b0, bus.out_valid}, 32'd1);
    do_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, r2, lat);
    chk("b2b_second_result", r2, 32'hFFFF_FFFE);
    chk("b2b_second_latency", 32'(lat), 32'd33);
    @(posedge clk);
    #1;
    chk("out_valid_one_cycle", {31'b0, bus.out_valid}, 32'd0);
    chk("idle_in_ready", {31'b0, bus.in_ready}, 32'd1);

    // flush at BUSY cycle 10
    keep = bus.result;
    bus.in_valid = 1'b1;
    bus.op = 3'd5;
    bus.a = 32'd100;
    bus.b = 32'd7;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    chk("flush_busy_in_ready", {31'b0, bus.in_ready}, 32'd0);
    repeat (9) @(posedge clk);
    #1;
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("flush_out_valid", {31'b0, bus.out_valid}, 32'd0);
    ov_cnt = 0;
    repeat (40) begin
      @(posedge clk);
      #1;
      if (bus.out_valid) ov_cnt++;
    end
    chk("flush_no_out_valid", 32'(ov_cnt), 32'd0);
    chk("flush_result_kept", bus.result, keep);

    // flush with a request in the same cycle drops the request
    bus.in_valid = 1'b1;
    bus.flush = 1'b1;
    bus.op = 3'd0;
    bus.a = 32'd3;
    bus.b = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.flush = 1'b0;
    chk("flush_drop_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("flush_drop_out_valid", {31'b0, bus.out_valid}, 32'd0);

    // reset in the middle of an operation
    bus.in_valid = 1'b1;
    bus.op = 3'd4;
    bus.a = 32'd1000;
    bus.b = 32'd3;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_result", bus.result, 32'h0);
    chk("midrst_in_ready", {31'b0, bus.in_ready}, 32'd1);
    chk("midrst_out_valid", {31'b0, bus.out_valid}, 32'd0);
    do_op(3'd4, 32'hFFFF_FFF9, 32'd2, r, lat);
    chk("post_rst_result", r, 32'hFFFF_FFFD);
    chk("post_rst_latency", 32'(lat), 32'd33);

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
